// File: rtl/thermometer_pkg.sv
// Shared constants and frame formatting for the TMP125 temperature-sensor emulator.
package thermometer_pkg;

  localparam int c_temp_w    = 10;
  localparam int c_frame_w   = 16;
  localparam int c_calc_w    = 12;
  localparam int c_temp_min  = -220;
  localparam int c_temp_max  = 500;
  localparam int c_amb_step  = 1;
  localparam int c_hvac_step = 4;

  // Sensor word: sign-extended reading left-justified below a zero MSB.
  function automatic logic [c_frame_w-1:0] make_frame(input logic [c_temp_w-1:0] temp);
    return {1'b0, temp, 5'b00000};
  endfunction

endpackage

// File: rtl/therm_spi_tx.sv
// Read-only SPI transmitter: reloads the sensor frame while deselected, shifts MSB first while selected.
module therm_spi_tx
  import thermometer_pkg::*;
#(
  parameter logic [c_frame_w-1:0] g_reset_frame = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic [c_frame_w-1:0] frame,
  output logic                 so
);

  logic [c_frame_w-1:0] shift_r;
  logic                 armed_r;

  // Load on deselect, shift on select; armed blocks output after a reset until CS is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= g_reset_frame;
      armed_r <= 1'b0;
    end else if (cs_n) begin
      shift_r <= frame;
      armed_r <= 1'b1;
    end else begin
      shift_r <= {shift_r[c_frame_w-2:0], 1'b0};
      armed_r <= armed_r;
    end
  end

  assign so = ~cs_n & armed_r & shift_r[c_frame_w-1];

endmodule

// File: rtl/thermometer_model.sv
// TMP125 emulator: once-per-second saturating room-temperature drift served as a 16-bit SPI frame.
module thermometer_model
  import thermometer_pkg::*;
#(
  parameter int g_spi_clk_freq = 10000,
  parameter int g_init_temp    = 80
) (
  input  logic i_spi_clk,
  input  logic i_rst_n,
  input  logic i_spi_cs_n,
  input  logic i_spi_si,
  output logic o_spi_so,
  input  logic i_heat,
  input  logic i_cool,
  input  logic i_amb_hc
);

  localparam int c_cnt_w = (g_spi_clk_freq > 1) ? $clog2(g_spi_clk_freq) : 1;
  localparam logic [c_cnt_w-1:0]   c_cnt_last    = c_cnt_w'(g_spi_clk_freq - 1);
  localparam logic [c_temp_w-1:0]  c_init_temp   = c_temp_w'(g_init_temp);
  localparam logic [c_frame_w-1:0] c_reset_frame = make_frame(c_init_temp);

  logic [c_cnt_w-1:0]         tick_cnt_r;
  logic                       tick_s;
  logic [c_temp_w-1:0]        temp_r;
  logic signed [c_calc_w-1:0] delta_s;
  logic signed [c_calc_w-1:0] sum_s;
  logic [c_temp_w-1:0]        next_temp_s;
  logic                       unused_si_s;

  assign unused_si_s = i_spi_si;
  assign tick_s      = (tick_cnt_r == c_cnt_last);

  // One-second timebase counted in SPI clock cycles.
  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + c_cnt_w'(1);
    end
  end

  // Drift step: ambient always applies; heat and cool cancel when both are on.
  always_comb begin
    delta_s = i_amb_hc ? c_calc_w'(c_amb_step) : -c_calc_w'(c_amb_step);
    if (i_heat) begin
      delta_s = delta_s + c_calc_w'(c_hvac_step);
    end else begin
      delta_s = delta_s;
    end
    if (i_cool) begin
      delta_s = delta_s - c_calc_w'(c_hvac_step);
    end else begin
      delta_s = delta_s;
    end
    sum_s = {{(c_calc_w-c_temp_w){temp_r[c_temp_w-1]}}, temp_r} + delta_s;
    if (sum_s > $signed(c_calc_w'(c_temp_max))) begin
      next_temp_s = c_temp_w'(c_temp_max);
    end else if (sum_s < $signed(c_calc_w'(c_temp_min))) begin
      next_temp_s = c_temp_w'(c_temp_min);
    end else begin
      next_temp_s = sum_s[c_temp_w-1:0];
    end
  end

  // Temperature accumulator, updated only on the tick.
  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      temp_r <= c_init_temp;
    end else if (tick_s) begin
      temp_r <= next_temp_s;
    end else begin
      temp_r <= temp_r;
    end
  end

  therm_spi_tx #(
    .g_reset_frame(c_reset_frame)
  ) u_spi_tx (
    .clk   (i_spi_clk),
    .rst_n (i_rst_n),
    .cs_n  (i_spi_cs_n),
    .frame (make_frame(temp_r)),
    .so    (o_spi_so)
  );

endmodule

// File: tb/tb_thermometer_model.sv
// Directed self-checking bench: four emulator instances covering drift, saturation and SPI framing.
module tb_thermometer_model;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cs_n = 4'b1111;
  logic [3:0] si = 4'b0000;
  logic [3:0] heat = 4'b0000;
  logic [3:0] cool = 4'b0000;
  logic [3:0] amb = 4'b0000;
  wire  [3:0] so;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  thermometer_model #(.g_spi_clk_freq(100), .g_init_temp(80)) dut0 (
    .i_spi_clk(clk), .i_rst_n(rst_n), .i_spi_cs_n(cs_n[0]), .i_spi_si(si[0]),
    .o_spi_so(so[0]), .i_heat(heat[0]), .i_cool(cool[0]), .i_amb_hc(amb[0]));

  thermometer_model #(.g_spi_clk_freq(100), .g_init_temp(498)) dut1 (
    .i_spi_clk(clk), .i_rst_n(rst_n), .i_spi_cs_n(cs_n[1]), .i_spi_si(si[1]),
    .o_spi_so(so[1]), .i_heat(heat[1]), .i_cool(cool[1]), .i_amb_hc(amb[1]));

  thermometer_model #(.g_spi_clk_freq(100), .g_init_temp(-218)) dut2 (
    .i_spi_clk(clk), .i_rst_n(rst_n), .i_spi_cs_n(cs_n[2]), .i_spi_si(si[2]),
    .o_spi_so(so[2]), .i_heat(heat[2]), .i_cool(cool[2]), .i_amb_hc(amb[2]));

  thermometer_model #(.g_spi_clk_freq(10000), .g_init_temp(80)) dut3 (
    .i_spi_clk(clk), .i_rst_n(rst_n), .i_spi_cs_n(cs_n[3]), .i_spi_si(si[3]),
    .o_spi_so(so[3]), .i_heat(heat[3]), .i_cool(cool[3]), .i_amb_hc(amb[3]));

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // 16-bit read starting at a negedge; samples each bit just before the shifting posedge.
  task automatic read_frame(input int d, output logic [15:0] f);
    f = 16'h0000;
    cs_n[d] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      f = {f[14:0], so[d]};
      @(negedge clk);
    end
    cs_n[d] = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_read(input int d, input string name, input logic [15:0] exp);
    logic [15:0] f;
    read_frame(d, f);
    total++;
    if (f !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, f, exp);
    end
  endtask

  task automatic test_reset();
    amb = 4'b0000; heat = 4'b0000; cool = 4'b0000; cs_n = 4'b1111;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (so[0] !== 1'b0) begin bad++; $display("FAIL reset_so: got %b expected 0", so[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go_to(3);
    total++;
    if (so[0] !== 1'b0) begin bad++; $display("FAIL idle_so: got %b expected 0", so[0]); end
    go_to(10);
    check_read(0, "reset_frame", 16'h0A00);
  endtask

  task automatic test_amb_cool();
    amb[0] = 1'b0; heat[0] = 1'b0; cool[0] = 1'b0;
    do_reset();
    go_to(101);
    check_read(0, "amb_cool_tick1", 16'h09E0);
    go_to(201);
    check_read(0, "amb_cool_tick2", 16'h09C0);
  endtask

  task automatic test_heat();
    amb[0] = 1'b1; heat[0] = 1'b1; cool[0] = 1'b0;
    do_reset();
    go_to(301);
    check_read(0, "heat_3ticks", 16'h0BE0);
    amb[0] = 1'b0; heat[0] = 1'b1; cool[0] = 1'b1;
    go_to(401);
    check_read(0, "heat_cool_cancel", 16'h0BC0);
    heat[0] = 1'b0; cool[0] = 1'b0;
  endtask

  task automatic test_saturation();
    amb[1] = 1'b1; heat[1] = 1'b1; cool[1] = 1'b0;
    amb[2] = 1'b0; heat[2] = 1'b0; cool[2] = 1'b1;
    do_reset();
    go_to(101);
    check_read(1, "sat_high_tick1", 16'h3E80);
    check_read(2, "sat_low_tick1", 16'h6480);
    go_to(201);
    check_read(1, "sat_high_tick2", 16'h3E80);
    check_read(2, "sat_low_tick2", 16'h6480);
  endtask

  task automatic test_long_read();
    logic [19:0] f;
    amb[0] = 1'b0; heat[0] = 1'b0; cool[0] = 1'b0;
    do_reset();
    go_to(10);
    f = 20'h00000;
    cs_n[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      si[0] = 1'($urandom_range(1, 0));
      #1;
      f = {f[18:0], so[0]};
      @(negedge clk);
    end
    cs_n[0] = 1'b1;
    si[0] = 1'b0;
    total++;
    if (f !== 20'h0A000) begin bad++; $display("FAIL long_read: got %h expected 0a000", f); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] f;
    go_to(40);
    f = 8'h00;
    cs_n[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      f = {f[6:0], so[0]};
      @(negedge clk);
    end
    cs_n[0] = 1'b1;
    #1;
    total++;
    if (f !== 8'h0A) begin bad++; $display("FAIL abort_half: got %h expected 0a", f); end
    total++;
    if (so[0] !== 1'b0) begin bad++; $display("FAIL abort_so: got %b expected 0", so[0]); end
    @(negedge clk);
    check_read(0, "after_abort", 16'h0A00);
  endtask

  task automatic test_tick_during_read();
    amb[0] = 1'b0;
    do_reset();
    go_to(92);
    check_read(0, "tick_in_read", 16'h0A00);
    go_to(120);
    check_read(0, "after_tick_read", 16'h09E0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    go_to(10);
    cs_n[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (so[0] !== 1'b0) begin bad++; $display("FAIL reset_mid_so: got %b expected 0", so[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (so[0] !== 1'b0) begin bad++; $display("FAIL post_reset_so%0d: got %b expected 0", i, so[0]); end
    end
    cs_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_read(0, "after_reset_mid", 16'h0A00);
  endtask

  task automatic test_default_rate();
    amb[3] = 1'b0; heat[3] = 1'b0; cool[3] = 1'b0;
    do_reset();
    go_to(10001);
    check_read(3, "default_tick1", 16'h09E0);
    go_to(20001);
    check_read(3, "default_tick2", 16'h09C0);
  endtask

  initial begin
    test_reset();
    test_amb_cool();
    test_heat();
    test_saturation();
    test_long_read();
    test_abort();
    test_tick_during_read();
    test_reset_mid();
    test_default_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
